// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: control word, ID/EX and EX/MEM register payloads,
// ALU and branch encodings, forwarding select.
// Optional feature macro: EX_MUL_EN adds the ALU_MUL encoding.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
`ifdef EX_MUL_EN
    , ALU_MUL = 4'd10
`endif
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } branch_type_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // All-zero control word is a bubble: no write, no memory access, no redirect.
  typedef struct packed {
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         alu_src;
    logic         a_is_pc;
    logic         branch;
    logic         jump;
    logic         jalr;
    alu_op_e      alu_op;
    branch_type_e branch_type;
  } control_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    control_t          ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   store_data;
    logic [REG_AW-1:0] rd;
    control_t          ctrl;
  } ex_mem_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU.
// Ports: a, b operands; alu_op operation select; result output.
// Unlisted encodings (including the multiply code) fall through to add.
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         alu_op,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = a + b;
    case (alu_op)
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result = XLEN'(a < b);
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = a + b;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, EX/MEM register.
// Ports: clk, rst (sync, active-high); id_ex_in; wb_we/wb_rd/wb_data forward source;
//        stall/flush register control; redirect_valid/redirect_pc fetch redirect;
//        stall_req busy indication; ex_mem_out EX/MEM register.
// Optional feature macro: EX_MUL_EN adds a 32-cycle iterative shift-add multiplier.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  id_ex_t            id_ex_in,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              stall,
  input  logic              flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              stall_req,
  output ex_mem_t           ex_mem_out
);

  control_t        ctrl;
  fwd_sel_e        sel1, sel2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_y;
  logic            taken;
  ex_mem_t         bubble, load_val, ex_mem_d;

  assign ctrl = id_ex_in.ctrl;

  // Forward select: MEM beats WB; x0 never forwards.
  always_comb begin
    sel1 = FWD_REG;
    sel2 = FWD_REG;
    if (ex_mem_out.ctrl.reg_write && ex_mem_out.rd == id_ex_in.rs1 && id_ex_in.rs1 != 5'd0)
      sel1 = FWD_MEM;
    else if (wb_we && wb_rd == id_ex_in.rs1 && id_ex_in.rs1 != 5'd0)
      sel1 = FWD_WB;
    if (ex_mem_out.ctrl.reg_write && ex_mem_out.rd == id_ex_in.rs2 && id_ex_in.rs2 != 5'd0)
      sel2 = FWD_MEM;
    else if (wb_we && wb_rd == id_ex_in.rs2 && id_ex_in.rs2 != 5'd0)
      sel2 = FWD_WB;
  end

  always_comb begin
    case (sel1)
      FWD_MEM: fwd_rs1 = ex_mem_out.alu_result;
      FWD_WB:  fwd_rs1 = wb_data;
      default: fwd_rs1 = id_ex_in.rs1_data;
    endcase
    case (sel2)
      FWD_MEM: fwd_rs2 = ex_mem_out.alu_result;
      FWD_WB:  fwd_rs2 = wb_data;
      default: fwd_rs2 = id_ex_in.rs2_data;
    endcase
  end

  assign op_a = ctrl.a_is_pc ? id_ex_in.pc  : fwd_rs1;
  assign op_b = ctrl.alu_src ? id_ex_in.imm : fwd_rs2;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .alu_op (ctrl.alu_op),
    .result (alu_y)
  );

  // Branch condition on forwarded register operands.
  always_comb begin
    taken = 1'b0;
    case (ctrl.branch_type)
      BR_EQ:   taken = (fwd_rs1 == fwd_rs2);
      BR_NE:   taken = (fwd_rs1 != fwd_rs2);
      BR_LT:   taken = ($signed(fwd_rs1) <  $signed(fwd_rs2));
      BR_GE:   taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      BR_LTU:  taken = (fwd_rs1 <  fwd_rs2);
      BR_GEU:  taken = (fwd_rs1 >= fwd_rs2);
      default: taken = 1'b0;
    endcase
  end

  assign redirect_pc    = ctrl.jalr ? ((fwd_rs1 + id_ex_in.imm) & ~XLEN'(1))
                                    : (id_ex_in.pc + id_ex_in.imm);
  assign redirect_valid = ((ctrl.branch & taken) | ctrl.jump) & ~stall & ~stall_req;

  always_comb begin
    bubble    = '0;
    bubble.pc = RESET_PC;
  end

  always_comb begin
    load_val.pc         = id_ex_in.pc;
    load_val.alu_result = ctrl.jump ? (id_ex_in.pc + XLEN'(4)) : alu_y;
    load_val.store_data = fwd_rs2;
    load_val.rd         = id_ex_in.rd;
    load_val.ctrl       = ctrl;
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;

  localparam int unsigned CNT_W = 5;

  mul_state_e        state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   mcand, mplier, acc, mul_pc, mul_sd;
  logic [REG_AW-1:0] mul_rd;
  control_t          mul_ctrl;
  logic              is_mul;

  assign is_mul = (ctrl.alu_op == ALU_MUL);

  always_ff @(posedge clk) begin
    if (rst) state <= MUL_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MUL_IDLE: if (is_mul && !stall && !flush) state_nx = MUL_BUSY;
      MUL_BUSY: if (flush) state_nx = MUL_IDLE;
                else if (cnt == '0) state_nx = MUL_DONE;
      MUL_DONE: if (flush || !stall) state_nx = MUL_IDLE;
      default:  state_nx = MUL_IDLE;
    endcase
  end

  // Accept cycle and BUSY both hold the front end.
  assign stall_req = (state == MUL_BUSY) || (state == MUL_IDLE && is_mul);

  // Shift-add datapath: one multiplier bit per BUSY cycle, counter 31..0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      mul_pc   <= '0;
      mul_sd   <= '0;
      mul_rd   <= '0;
      mul_ctrl <= '0;
    end else if (state == MUL_IDLE && state_nx == MUL_BUSY) begin
      cnt      <= CNT_W'(31);
      mcand    <= fwd_rs1;
      mplier   <= fwd_rs2;
      acc      <= '0;
      mul_pc   <= id_ex_in.pc;
      mul_sd   <= fwd_rs2;
      mul_rd   <= id_ex_in.rd;
      mul_ctrl <= ctrl;
    end else if (state == MUL_BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    ex_mem_d = load_val;
    if (state == MUL_BUSY || (state == MUL_IDLE && is_mul)) begin
      ex_mem_d = bubble;
    end else if (state == MUL_DONE) begin
      ex_mem_d.pc         = mul_pc;
      ex_mem_d.alu_result = acc;
      ex_mem_d.store_data = mul_sd;
      ex_mem_d.rd         = mul_rd;
      ex_mem_d.ctrl       = mul_ctrl;
    end
  end
`else
  assign stall_req = 1'b0;
  assign ex_mem_d  = load_val;
`endif

  // EX/MEM register: rst > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst)         ex_mem_out <= bubble;
    else if (flush)  ex_mem_out <= bubble;
    else if (!stall) ex_mem_out <= ex_mem_d;
  end

endmodule
